zion_dat_read_serializer: RTL and testbench
===========================================

# zion_dat_read_serializer

Sequential successor to the combinational sub-word read unit: accepts one wide data word plus start address, element width type and burst length, then streams consecutive sub-words of the selected width, one per handshake, onto a narrow output bus. Sits between wide buffer/memory read ports and narrow-datapath consumers (unpackers, per-element ALUs). Both sides use valid/ready handshakes. Wrap-around within the word is supported.

## Interface
- WIDTH_DATA_IN, 64: width of input word iDat.
- WIDTH_DATA_OUT, 32: width of oDat.
- NUM_TYPE, 3: number of element width types.
- TYPE_WIDTH[NUM_TYPE], {8,16,32}: element width per type.
  - Each entry is a power of two.
  - Each entry divides WIDTH_DATA_IN.
  - Each entry is at most WIDTH_DATA_OUT.
- WIDTH_ADDR, derived $clog2(WIDTH_DATA_IN/min(TYPE_WIDTH)): width of iAddr and iLen.
- WIDTH_TYPE, derived max(1,$clog2(NUM_TYPE)): width of iType.

Ports (clock and reset first):
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- iVld  input  1  request valid.
- oRdy  output  1  request ready.
- iDat  input  WIDTH_DATA_IN  source word.
- iAddr  input  WIDTH_ADDR  start element index, in units of the selected type.
- iLen  input  WIDTH_ADDR  beats minus one.
- iType  input  WIDTH_TYPE  width type select.
- oVld  output  1  element valid.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH_DATA_OUT  element, right-aligned.
- oLast  output  1  final beat of the burst.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - oRdy=1, oVld=0.
  - On iVld&&oRdy, register iDat, iType, iAddr, iLen and go to BUSY.
- Type and address resolution:
  - iType>=NUM_TYPE is treated as type 0.
  - N=WIDTH_DATA_IN/TYPE_WIDTH[t].
  - The effective pointer is iAddr mod N (low $clog2(N) bits); higher bits are ignored.
- BUSY:
  - oVld=1.
  - oDat = element[ptr] of the captured word, zero-extended to WIDTH_DATA_OUT.
  - oLast=1 when remaining count==0.
- Beat advance: on oVld&&iRdy, ptr=(ptr+1) mod N and count decrements.
- Wrap-around: element N-1 is followed by element 0.
  - iLen>=N is legal; the word is replayed cyclically.
  - Total beats = iLen+1, maximum 2^WIDTH_ADDR.
- Burst end: on acceptance of the oLast beat, return to IDLE unless a new request is taken in the same cycle.
- oRdy = IDLE || (oVld && iRdy && oLast). This is a combinational iRdy->oRdy path.
- Simultaneous last-beat acceptance and iVld: the new request is captured and the state stays BUSY. The new first beat appears the next cycle with no bubble.
- iVld in BUSY before the last beat is accepted: not accepted (oRdy=0). The requester must hold iVld and its payload stable until accepted.
- oDat, oLast and oVld are stable while oVld&&!iRdy.
- Reset:
  - rst=1 forces IDLE; captured registers clear; oDat=0, oVld=0, oLast=0.
  - oRdy=0 while rst=1 and 1 on the first cycle after deassertion.
  - Reset mid-burst drops the remaining beats.

## Timing
- Latency: first beat is valid on the cycle after the request is accepted.
- Throughput: one element per cycle with iRdy held high; zero-bubble between bursts.
- Outputs are registered except oRdy.
- Critical path: the N:1 element mux per type plus the type mux. This path is not pipelined.

## Configuration
- Macro ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN.
- Defined:
  - Adds port iSgn (input, 1), captured with the request.
  - When the captured iSgn=1, elements narrower than WIDTH_DATA_OUT are sign-extended from their MSB.
  - When the captured iSgn=0, elements are zero-extended.
- Undefined: no iSgn port; all elements are zero-extended.

## Test plan
All scenarios use default parameters and iDat=64'h8877_6655_4433_2211.
- Single-beat read: type 0, iAddr=2, iLen=0, iRdy=1.
  - Response: one cycle after accept, oDat=32'h33, oLast=1, oVld=1 for exactly 1 cycle.
  - oRdy=1 on the same cycle.
- Wrap-around burst: type 1, iAddr=2, iLen=3.
  - Response: 16'h6655, 16'h8877, 16'h2211, 16'h4433 on consecutive cycles; oLast only on the 4th beat.
- Backpressure: type 2, iAddr=0, iLen=1; iRdy low for 3 cycles during beat 2.
  - Response: beat 1 is 32'h4433_2211.
  - Beat 2, 32'h8877_6655 with oLast=1, holds stable for 3 cycles and is then accepted once.
- Back-to-back bursts: second request (type 0, iAddr=7, iLen=0) held valid during the last beat of the first burst.
  - Response: oRdy=1 in that cycle; next cycle oDat=32'h88; no idle cycle between the bursts.
- Reset mid-burst: type 0, iAddr=0, iLen=7; rst asserted after beat 3.
  - Response: next cycle oVld=0, oDat=0.
  - After rst deasserts, oRdy=1 and no further beats are emitted.
- Sign extension: macro defined, type 0, iAddr=7, iSgn=1 -> oDat=32'hFFFF_FF88.
  - Macro undefined -> oDat=32'h0000_0088.
  - Type 2 (full-width) with iSgn=1 -> oDat unchanged.

Source files
------------

// File: rtl/zion_dat_read_serializer_if.sv
// Request/response bundle for zion_dat_read_serializer: wide request in, narrow elements out.
// iSgn exists only when ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN is defined.
`timescale 1ns/1ps
interface zion_dat_read_serializer_if #(
   parameter int WIDTH_DATA_IN  = 64,
   parameter int WIDTH_DATA_OUT = 32,
   parameter int WIDTH_ADDR     = 3,
   parameter int WIDTH_TYPE     = 2
);
   logic                      iVld;
   logic                      oRdy;
   logic [WIDTH_DATA_IN-1:0]  iDat;
   logic [WIDTH_ADDR-1:0]     iAddr;
   logic [WIDTH_ADDR-1:0]     iLen;
   logic [WIDTH_TYPE-1:0]     iType;
   logic                      oVld;
   logic                      iRdy;
   logic [WIDTH_DATA_OUT-1:0] oDat;
   logic                      oLast;
`ifdef ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN
   logic                      iSgn;

   modport master (output iVld, iDat, iAddr, iLen, iType, iSgn, iRdy,
                   input  oRdy, oVld, oDat, oLast);
   modport slave  (input  iVld, iDat, iAddr, iLen, iType, iSgn, iRdy,
                   output oRdy, oVld, oDat, oLast);
`else
   modport master (output iVld, iDat, iAddr, iLen, iType, iRdy,
                   input  oRdy, oVld, oDat, oLast);
   modport slave  (input  iVld, iDat, iAddr, iLen, iType, iRdy,
                   output oRdy, oVld, oDat, oLast);
`endif
endinterface

// File: rtl/zion_dat_read_serializer.sv
// Streams sub-words of a captured wide word onto a narrow bus, one per handshake, wrapping within the word.
// Optional sign extension of narrow elements under ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN.
`timescale 1ns/1ps
module zion_dat_read_serializer #(
   parameter int WIDTH_DATA_IN             = 64,
   parameter int WIDTH_DATA_OUT            = 32,
   parameter int NUM_TYPE                  = 3,
   parameter int TYPE_WIDTH [NUM_TYPE]     = '{8, 16, 32}
) (
   input  logic                          clk,
   input  logic                          rst,
   zion_dat_read_serializer_if.slave     bus
);
   function automatic int minTypeWidth();
      int m;
      m = TYPE_WIDTH[0];
      for (int t = 1; t < NUM_TYPE; t++) begin
         if (TYPE_WIDTH[t] < m) m = TYPE_WIDTH[t];
         else                   m = m;
      end
      return m;
   endfunction

   localparam int WIDTH_ADDR = $clog2(WIDTH_DATA_IN / minTypeWidth());
   localparam int WIDTH_TYPE = (NUM_TYPE > 1) ? $clog2(NUM_TYPE) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   // Element count per type is a power of two, so "mod N" is a mask of N-1.
   function automatic logic [WIDTH_ADDR-1:0] ptrMask(input logic [WIDTH_TYPE-1:0] typ);
      logic [WIDTH_ADDR-1:0] m;
      m = '0;
      for (int t = 0; t < NUM_TYPE; t++) begin
         if (typ == WIDTH_TYPE'(t)) m = WIDTH_ADDR'(WIDTH_DATA_IN / TYPE_WIDTH[t] - 1);
         else                       m = m;
      end
      return m;
   endfunction

   function automatic logic [WIDTH_DATA_OUT-1:0] elemOf(
      input logic [WIDTH_DATA_IN-1:0] dat,
      input logic [WIDTH_TYPE-1:0]    typ,
      input logic [WIDTH_ADDR-1:0]    ptr,
      input logic                     sgn
   );
      logic [WIDTH_DATA_IN-1:0]  shifted;
      logic [WIDTH_DATA_OUT-1:0] res;
      shifted = '0;
      res     = '0;
      for (int t = 0; t < NUM_TYPE; t++) begin
         if (typ == WIDTH_TYPE'(t)) begin
            shifted = dat >> (int'(ptr) * TYPE_WIDTH[t]);
            for (int b = 0; b < WIDTH_DATA_OUT; b++) begin
               if (b < TYPE_WIDTH[t]) res[b] = shifted[b];
               else                   res[b] = sgn & shifted[TYPE_WIDTH[t]-1];
            end
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   logic [0:0]                state_r;
   logic [WIDTH_DATA_IN-1:0]  capDat_r;
   logic [WIDTH_TYPE-1:0]     capType_r;
   logic                      capSgn_r;
   logic [WIDTH_ADDR-1:0]     ptr_r;
   logic [WIDTH_ADDR-1:0]     cnt_r;
   logic                      vld_r;
   logic [WIDTH_DATA_OUT-1:0] dat_r;
   logic                      last_r;

   logic                      rdy_s;
   logic                      take_s;
   logic                      advance_s;
   logic [WIDTH_TYPE-1:0]     reqType_s;
   logic                      reqSgn_s;
   logic [WIDTH_ADDR-1:0]     reqPtr_s;
   logic [WIDTH_ADDR-1:0]     nextPtr_s;
   logic [WIDTH_DATA_OUT-1:0] elem_s;

   assign advance_s = vld_r && bus.iRdy;
   assign rdy_s     = !rst && ((state_r == IDLE) || (advance_s && last_r));
   assign take_s    = bus.iVld && rdy_s;

`ifdef ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN
   assign reqSgn_s = bus.iSgn;
`else
   assign reqSgn_s = 1'b0;
`endif

   // Resolve the request type/pointer and pick the element source for the next beat
   always_comb begin
      reqType_s = '0;
      reqPtr_s  = '0;
      nextPtr_s = '0;
      elem_s    = '0;
      if (int'(bus.iType) >= NUM_TYPE) reqType_s = '0;
      else                             reqType_s = bus.iType;
      reqPtr_s  = bus.iAddr & ptrMask(reqType_s);
      nextPtr_s = (ptr_r + WIDTH_ADDR'(1)) & ptrMask(capType_r);
      if (take_s) elem_s = elemOf(bus.iDat, reqType_s, reqPtr_s, reqSgn_s);
      else        elem_s = elemOf(capDat_r, capType_r, nextPtr_s, capSgn_r);
   end

   // Request capture, beat advance and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         capDat_r  <= '0;
         capType_r <= '0;
         capSgn_r  <= 1'b0;
         ptr_r     <= '0;
         cnt_r     <= '0;
         vld_r     <= 1'b0;
         dat_r     <= '0;
         last_r    <= 1'b0;
      end else if (take_s) begin
         state_r   <= BUSY;
         capDat_r  <= bus.iDat;
         capType_r <= reqType_s;
         capSgn_r  <= reqSgn_s;
         ptr_r     <= reqPtr_s;
         cnt_r     <= bus.iLen;
         vld_r     <= 1'b1;
         dat_r     <= elem_s;
         last_r    <= (bus.iLen == {WIDTH_ADDR{1'b0}});
      end else if (advance_s) begin
         if (last_r) begin
            state_r <= IDLE;
            vld_r   <= 1'b0;
            dat_r   <= '0;
            last_r  <= 1'b0;
         end else begin
            ptr_r   <= nextPtr_s;
            cnt_r   <= cnt_r - WIDTH_ADDR'(1);
            dat_r   <= elem_s;
            last_r  <= (cnt_r == WIDTH_ADDR'(1));
         end
      end else begin
         state_r <= state_r;
      end
   end

   assign bus.oRdy  = rdy_s;
   assign bus.oVld  = vld_r;
   assign bus.oDat  = dat_r;
   assign bus.oLast = last_r;
endmodule

// File: tb/tb_zion_dat_read_serializer.sv
// Directed self-checking bench for zion_dat_read_serializer (default parameters).
`timescale 1ns/1ps
module tb_zion_dat_read_serializer;
   logic clk;
   logic rst;
   int   nChecks;
   int   nPass;

   localparam logic [63:0] WORD = 64'h8877_6655_4433_2211;

   zion_dat_read_serializer_if #(
      .WIDTH_DATA_IN(64), .WIDTH_DATA_OUT(32), .WIDTH_ADDR(3), .WIDTH_TYPE(2)
   ) bus ();

   zion_dat_read_serializer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setSgn(input logic sgn);
`ifdef ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN
      bus.iSgn = sgn;
`else
      if (sgn) nChecks = nChecks;
`endif
   endtask

   task automatic request(input logic [1:0] typ, input logic [2:0] addr, input logic [2:0] len, input logic sgn);
      bus.iVld  = 1'b1;
      bus.iDat  = WORD;
      bus.iType = typ;
      bus.iAddr = addr;
      bus.iLen  = len;
      setSgn(sgn);
   endtask

   task automatic singleRead(input string tag, input logic [1:0] typ, input logic [2:0] addr,
                             input logic sgn, input logic [31:0] expDat);
      request(typ, addr, 3'd0, sgn);
      bus.iRdy = 1'b1;
      step();
      bus.iVld = 1'b0;
      #1;
      checkVal({tag, "_dat"}, bus.oDat, expDat);
      checkVal({tag, "_last"}, bus.oLast, 1'b1);
      step();
   endtask

   initial begin
      nChecks   = 0;
      nPass     = 0;
      rst       = 1'b1;
      bus.iVld  = 1'b0;
      bus.iRdy  = 1'b0;
      bus.iDat  = 64'h0;
      bus.iType = 2'd0;
      bus.iAddr = 3'd0;
      bus.iLen  = 3'd0;
      setSgn(1'b0);
      step();
      step();
      checkVal("rst_vld", bus.oVld, 1'b0);
      checkVal("rst_dat", bus.oDat, 32'h0);
      checkVal("rst_last", bus.oLast, 1'b0);
      checkVal("rst_rdy", bus.oRdy, 1'b0);
      rst = 1'b0;
      #1;
      checkVal("post_rst_rdy", bus.oRdy, 1'b1);

      // Single-beat read
      request(2'd0, 3'd2, 3'd0, 1'b0);
      bus.iRdy = 1'b1;
      step();
      bus.iVld = 1'b0;
      #1;
      checkVal("single_vld", bus.oVld, 1'b1);
      checkVal("single_dat", bus.oDat, 32'h33);
      checkVal("single_last", bus.oLast, 1'b1);
      checkVal("single_rdy", bus.oRdy, 1'b1);
      step();
      checkVal("single_done", bus.oVld, 1'b0);

      // Wrap-around burst of 16-bit elements
      request(2'd1, 3'd2, 3'd3, 1'b0);
      step();
      bus.iVld = 1'b0;
      #1;
      checkVal("wrap_b0", bus.oDat, 32'h6655);
      checkVal("wrap_l0", bus.oLast, 1'b0);
      step();
      checkVal("wrap_b1", bus.oDat, 32'h8877);
      checkVal("wrap_l1", bus.oLast, 1'b0);
      step();
      checkVal("wrap_b2", bus.oDat, 32'h2211);
      checkVal("wrap_l2", bus.oLast, 1'b0);
      step();
      checkVal("wrap_b3", bus.oDat, 32'h4433);
      checkVal("wrap_l3", bus.oLast, 1'b1);
      step();
      checkVal("wrap_done", bus.oVld, 1'b0);

      // Backpressure on the second 32-bit beat
      request(2'd2, 3'd0, 3'd1, 1'b0);
      step();
      bus.iVld = 1'b0;
      #1;
      checkVal("bp_b0", bus.oDat, 32'h4433_2211);
      checkVal("bp_l0", bus.oLast, 1'b0);
      step();
      bus.iRdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkVal($sformatf("bp_hold_dat%0d", i), bus.oDat, 32'h8877_6655);
         checkVal($sformatf("bp_hold_last%0d", i), bus.oLast, 1'b1);
         checkVal($sformatf("bp_hold_vld%0d", i), bus.oVld, 1'b1);
         checkVal($sformatf("bp_hold_rdy%0d", i), bus.oRdy, 1'b0);
         step();
      end
      bus.iRdy = 1'b1;
      #1;
      checkVal("bp_final_dat", bus.oDat, 32'h8877_6655);
      checkVal("bp_final_rdy", bus.oRdy, 1'b1);
      step();
      checkVal("bp_done", bus.oVld, 1'b0);

      // Back-to-back bursts with the second request pending early
      request(2'd0, 3'd0, 3'd1, 1'b0);
      step();
      request(2'd0, 3'd7, 3'd0, 1'b0);
      #1;
      checkVal("b2b_b0", bus.oDat, 32'h11);
      checkVal("b2b_rdy0", bus.oRdy, 1'b0);
      step();
      checkVal("b2b_b1", bus.oDat, 32'h22);
      checkVal("b2b_l1", bus.oLast, 1'b1);
      checkVal("b2b_rdy1", bus.oRdy, 1'b1);
      step();
      bus.iVld = 1'b0;
      #1;
      checkVal("b2b_vld2", bus.oVld, 1'b1);
      checkVal("b2b_b2", bus.oDat, 32'h88);
      checkVal("b2b_l2", bus.oLast, 1'b1);
      step();
      checkVal("b2b_done", bus.oVld, 1'b0);

      // Reset mid-burst
      request(2'd0, 3'd0, 3'd7, 1'b0);
      step();
      bus.iVld = 1'b0;
      step();
      step();
      checkVal("mrst_b2", bus.oDat, 32'h33);
      step();
      checkVal("mrst_b3", bus.oDat, 32'h44);
      rst = 1'b1;
      #1;
      checkVal("mrst_rdy_in_rst", bus.oRdy, 1'b0);
      step();
      checkVal("mrst_vld", bus.oVld, 1'b0);
      checkVal("mrst_dat", bus.oDat, 32'h0);
      rst = 1'b0;
      #1;
      checkVal("mrst_rdy", bus.oRdy, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         checkVal($sformatf("mrst_quiet%0d", i), bus.oVld, 1'b0);
      end

      // Cyclic replay of a full-width word
      request(2'd2, 3'd1, 3'd2, 1'b0);
      step();
      bus.iVld = 1'b0;
      #1;
      checkVal("replay_b0", bus.oDat, 32'h8877_6655);
      step();
      checkVal("replay_b1", bus.oDat, 32'h4433_2211);
      step();
      checkVal("replay_b2", bus.oDat, 32'h8877_6655);
      checkVal("replay_l2", bus.oLast, 1'b1);
      step();

      // Address masking, invalid type fallback and sign handling
      singleRead("mask_t2_a5", 2'd2, 3'd5, 1'b0, 32'h8877_6655);
      singleRead("badtype", 2'd3, 3'd5, 1'b0, 32'h66);
      singleRead("t0_nosgn", 2'd0, 3'd7, 1'b0, 32'h88);
`ifdef ZION_DAT_READ_SERIALIZER_SIGN_EXT_EN
      singleRead("t0_sgn", 2'd0, 3'd7, 1'b1, 32'hFFFF_FF88);
      singleRead("t1_sgn", 2'd1, 3'd3, 1'b1, 32'hFFFF_8877);
      singleRead("t0_sgn_pos", 2'd0, 3'd6, 1'b1, 32'h77);
`else
      singleRead("t0_sgn", 2'd0, 3'd7, 1'b1, 32'h88);
      singleRead("t1_sgn", 2'd1, 3'd3, 1'b1, 32'h8877);
      singleRead("t0_sgn_pos", 2'd0, 3'd6, 1'b1, 32'h77);
`endif
      singleRead("t2_sgn", 2'd2, 3'd1, 1'b1, 32'h8877_6655);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
